// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and load-use hazard unit for the MIPS pipeline. It keeps a
//   scoreboard of in-flight destinations, with one entry per stage after ID
//   (entry 1 = EX ... entry DEPTH = WB). For each ID read port it returns a
//   bypass-stage select, and it raises stall while an operand is not yet
//   produced.
//
//   Optional feature macro: FWD_PERF_CNT_EN (adds stall/forward perf counters).
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   id_valid      ID holds a real instruction
//   id_rd_en      per-port register read enable
//   id_rd_addr    per-port read address, port p at [5p+4:5p]
//   id_we/id_wa   ID instruction writes RF / destination register
//   id_rdy_stg    first stage whose output holds the result (0 treated as 1)
//   freeze        external pipeline hold; scoreboard does not shift
//   kill          per-stage flush mask, bit k-1 = stage k
//   fwd_sel       per-port select: 0 = register file, k = bypass from stage k
//   stall         hold PC/IF/ID and insert a bubble into EX
//   stall_cnt     non-frozen stall cycles (perf build only, else 0)
//   fwd_cnt       cycles with any nonzero select (perf build only, else 0)
module fwd_hazard_unit #(
   parameter int NRP   = 2,
   parameter int DEPTH = 3,
   parameter int SELW  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [NRP-1:0]        id_rd_en,
   input  logic [NRP*5-1:0]      id_rd_addr,
   input  logic                  id_we,
   input  logic [4:0]            id_wa,
   input  logic [SELW-1:0]       id_rdy_stg,
   input  logic                  freeze,
   input  logic [DEPTH-1:0]      kill,
   output logic [NRP*SELW-1:0]   fwd_sel,
   output logic                  stall,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           fwd_cnt
);

   // Entry k lives at index k-1.
   logic [DEPTH-1:0]            v_q, v_d;
   logic [DEPTH-1:0]            we_q, we_d;
   logic [DEPTH-1:0][4:0]       wa_q, wa_d;
   logic [DEPTH-1:0][SELW-1:0]  rdy_q, rdy_d;

   logic [NRP-1:0]              haz;
   logic [SELW-1:0]             id_rdy_n;
   logic [4:0]                  addr;
   logic                        hit;
   logic [SELW-1:0]             hit_k;
   logic [SELW-1:0]             hit_rdy;

   // Ready stage is normalised on entry so lookups never see a 0.
   always_comb begin
      id_rdy_n = (id_rdy_stg == '0) ? SELW'(1) : id_rdy_stg;
   end

   // Lookup: the first (youngest) matching entry decides forward vs hazard.
   always_comb begin
      fwd_sel = '0;
      haz     = '0;
      addr    = '0;
      hit     = 1'b0;
      hit_k   = '0;
      hit_rdy = '0;
      for (int unsigned p = 0; p < NRP; p++) begin
         addr    = id_rd_addr[5*p +: 5];
         hit     = 1'b0;
         hit_k   = '0;
         hit_rdy = '0;
         for (int unsigned k = 1; k <= DEPTH; k++) begin
            if (!hit && v_q[k-1] && we_q[k-1] && (wa_q[k-1] == addr)) begin
               hit     = 1'b1;
               hit_k   = SELW'(k);
               hit_rdy = rdy_q[k-1];
            end
         end
         if (id_rd_en[p] && (addr != 5'd0) && hit) begin
            if (hit_k >= hit_rdy) begin
               fwd_sel[p*SELW +: SELW] = hit_k;
            end else begin
               haz[p] = 1'b1;
            end
         end
      end
      stall = id_valid && (|haz);
   end

   // Kill is applied after the shift/hold choice, so it clears the
   // destination stage on a shift and the entry itself while frozen.
   always_comb begin
      v_d   = v_q;
      we_d  = we_q;
      wa_d  = wa_q;
      rdy_d = rdy_q;
      if (!freeze) begin
         for (int unsigned k = 1; k < DEPTH; k++) begin
            v_d[k]   = v_q[k-1];
            we_d[k]  = we_q[k-1];
            wa_d[k]  = wa_q[k-1];
            rdy_d[k] = rdy_q[k-1];
         end
         v_d[0]   = id_valid && !stall;
         we_d[0]  = id_we;
         wa_d[0]  = id_wa;
         rdy_d[0] = id_rdy_n;
      end
      v_d = v_d & ~kill;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q   <= '0;
         we_q  <= '0;
         wa_q  <= '0;
         rdy_q <= '0;
      end else begin
         v_q   <= v_d;
         we_q  <= we_d;
         wa_q  <= wa_d;
         rdy_q <= rdy_d;
      end
   end

`ifdef FWD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] fwd_cnt_q, fwd_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (stall && !freeze && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if ((fwd_sel != '0) && (fwd_cnt_q != '1)) begin
         fwd_cnt_d = fwd_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign fwd_cnt   = fwd_cnt_q;
`else
   assign stall_cnt = '0;
   assign fwd_cnt   = '0;
`endif

endmodule
